// File: rtl/ysyx_25040118_wb_arbiter_pkg.sv
// Shared writeback definitions for the regfile write-port arbiter and its
// scoreboard: register/data widths, the implemented register count, the
// request record and the source identifiers.
package ysyx_25040118_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 16;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  // A destination is a real regfile write only if it is not x0 and is implemented.
  function automatic logic rd_real(input logic [REG_AW-1:0] rd, input int unsigned nreg);
    return (rd != '0) && (int'(rd) < int'(nreg));
  endfunction

endpackage

// File: rtl/ysyx_25040118_wb_arbiter_if.sv
// Writeback bus bundle: EXU and LSU valid/ready request channels plus the
// registered regfile write port.
//   master : writeback sources / regfile side (drives requests, sees ready + rf_*)
//   slave  : the arbiter (drives ready and rf_*)
interface ysyx_25040118_wb_arbiter_if
  import ysyx_25040118_pkg::*;
  ;

  logic              exu_valid;
  logic              exu_ready;
  logic [REG_AW-1:0] exu_rd;
  logic [XLEN-1:0]   exu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [REG_AW-1:0] lsu_rd;
  logic [XLEN-1:0]   lsu_data;
  logic              rf_wen;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;

  modport master (
    output exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
    input  exu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata
  );

  modport slave (
    input  exu_valid, exu_rd, exu_data, lsu_valid, lsu_rd, lsu_data,
    output exu_ready, lsu_ready, rf_wen, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/ysyx_25040118_wb_arbiter_scoreboard.sv
// Pending-write scoreboard. One saturating counter per implemented register
// (x1..x(NREG-1)) tracks issued-but-unretired writes.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   issue_v, issue_rd   decode issued a write to issue_rd (increment)
//   ret_v, ret_rd       arbiter accepted a real write to ret_rd (decrement)
//   rf_wen, rf_waddr    registered regfile write stage (still counts as busy)
//   chk_rs1, chk_rs2    decode sources to look up
//   rs1_busy, rs2_busy  combinational busy flags
//   sb_err              sticky counter overflow/underflow flag
module ysyx_25040118_scoreboard
  import ysyx_25040118_pkg::*;
#(
  parameter int unsigned NREG = 16,
  parameter int unsigned CW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_v,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              ret_v,
  input  logic [REG_AW-1:0] ret_rd,
  input  logic              rf_wen,
  input  logic [REG_AW-1:0] rf_waddr,
  input  logic [REG_AW-1:0] chk_rs1,
  input  logic [REG_AW-1:0] chk_rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              sb_err
);

  logic [CW-1:0] cnt     [1:NREG-1];
  logic [CW-1:0] cnt_nxt [1:NREG-1];
  logic          err_nxt;
  logic          issue_ok;
  logic          inc;
  logic          dec;

  assign issue_ok = issue_v && rd_real(issue_rd, NREG);

  always_comb begin
    cnt_nxt = cnt;
    err_nxt = sb_err;
    inc     = 1'b0;
    dec     = 1'b0;
    for (int unsigned r = 1; r < NREG; r++) begin
      inc = issue_ok && (issue_rd == REG_AW'(r));
      dec = ret_v && (ret_rd == REG_AW'(r));
      // Simultaneous increment and decrement of one register cancel out.
      if (inc && !dec) begin
        if (cnt[r] == '1) err_nxt = 1'b1;
        else              cnt_nxt[r] = cnt[r] + 1'b1;
      end else if (dec && !inc) begin
        if (cnt[r] == '0) err_nxt = 1'b1;
        else              cnt_nxt[r] = cnt[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 1; r < NREG; r++) cnt[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      sb_err <= err_nxt;
    end
  end

  // The output stage counts as busy because the regfile is written only at
  // the end of the rf_wen cycle and no bypass exists.
  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (chk_rs1 == REG_AW'(r) && (cnt[r] != '0 || (rf_wen && rf_waddr == chk_rs1)))
        rs1_busy = 1'b1;
      if (chk_rs2 == REG_AW'(r) && (cnt[r] != '0 || (rf_wen && rf_waddr == chk_rs2)))
        rs2_busy = 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_25040118_wb_arbiter.sv
// Regfile write-port arbiter: round-robin between EXU and LSU writeback
// requests, registered one-cycle output stage to the regfile, and a RAW
// scoreboard for decode.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   bus (slave)                  EXU/LSU valid/ready requests, rf_wen/waddr/wdata
//   issue_v, issue_rd            decode issued a write to issue_rd
//   chk_rs1, chk_rs2             decode sources to check
//   rs1_busy, rs2_busy, sb_err   scoreboard outputs
module ysyx_25040118_wb_arbiter
  import ysyx_25040118_pkg::*;
#(
  parameter int unsigned NREG = ysyx_25040118_pkg::NREG,
  parameter int unsigned CW   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_25040118_wb_arbiter_if.slave     bus,
  input  logic                          issue_v,
  input  logic [REG_AW-1:0]             issue_rd,
  input  logic [REG_AW-1:0]             chk_rs1,
  input  logic [REG_AW-1:0]             chk_rs2,
  output logic                          rs1_busy,
  output logic                          rs2_busy,
  output logic                          sb_err
);

  // prio holds the source favoured on the next conflict.
  src_e    prio, prio_nxt;
  logic    grant_exu, grant_lsu, accept;
  wb_req_t req;
  logic    ret_v;

  always_ff @(posedge clk) begin
    if (rst) prio <= SRC_EXU;
    else     prio <= prio_nxt;
  end

  always_comb begin
    prio_nxt = prio;
    if (grant_exu)      prio_nxt = SRC_LSU;
    else if (grant_lsu) prio_nxt = SRC_EXU;
  end

  always_comb begin
    grant_exu = !rst && bus.exu_valid && (!bus.lsu_valid || prio == SRC_EXU);
    grant_lsu = !rst && bus.lsu_valid && (!bus.exu_valid || prio == SRC_LSU);
  end

  assign bus.exu_ready = grant_exu;
  assign bus.lsu_ready = grant_lsu;
  assign accept        = grant_exu || grant_lsu;

  always_comb begin
    if (grant_lsu) req = '{rd: bus.lsu_rd, data: bus.lsu_data};
    else           req = '{rd: bus.exu_rd, data: bus.exu_data};
  end

  // x0 / unimplemented destinations are accepted but never written.
  assign ret_v = accept && rd_real(req.rd, NREG);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rf_wen   <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else begin
      bus.rf_wen <= ret_v;
      if (accept) begin
        bus.rf_waddr <= req.rd;
        bus.rf_wdata <= req.data;
      end
    end
  end

  ysyx_25040118_scoreboard #(
    .NREG (NREG),
    .CW   (CW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .issue_v  (issue_v),
    .issue_rd (issue_rd),
    .ret_v    (ret_v),
    .ret_rd   (req.rd),
    .rf_wen   (bus.rf_wen),
    .rf_waddr (bus.rf_waddr),
    .chk_rs1  (chk_rs1),
    .chk_rs2  (chk_rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .sb_err   (sb_err)
  );

endmodule

// File: tb/tb_ysyx_25040118_wb_arbiter.sv
// Self-checking bench for ysyx_25040118_wb_arbiter: directed scenarios plus
// randomized traffic compared against a behavioural model.
module tb_ysyx_25040118_wb_arbiter;
  import ysyx_25040118_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_v;
  logic [4:0] issue_rd, chk_rs1, chk_rs2;
  logic       rs1_busy, rs2_busy, sb_err;

  always #5 clk = ~clk;

  ysyx_25040118_wb_arbiter_if bus ();

  ysyx_25040118_wb_arbiter #(.NREG(16), .CW(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .issue_v  (issue_v),
    .issue_rd (issue_rd),
    .chk_rs1  (chk_rs1),
    .chk_rs2  (chk_rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .sb_err   (sb_err)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_cnt [32];
  bit          m_last_lsu;
  bit          m_wen;
  int          m_waddr;
  logic [31:0] m_wdata;
  bit          m_err;
  bit          g_exu, g_lsu;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit real_rd(input int rd);
    return rd != 0 && rd < 16;
  endfunction

  function automatic bit m_busy(input int rs);
    return real_rd(rs) && (m_cnt[rs] != 0 || (m_wen && m_waddr == rs));
  endfunction

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_last_lsu = 1'b1;
    m_wen = 1'b0; m_waddr = 0; m_wdata = '0; m_err = 1'b0;
  endtask

  task automatic idle();
    bus.exu_valid = 1'b0; bus.lsu_valid = 1'b0;
    issue_v = 1'b0;
  endtask

  // One clock: check combinational outputs, advance, check registered outputs.
  task automatic step();
    bit          was_rst, inc_ok, dec_ok;
    int          grd, ird;
    logic [31:0] gdata;
    #1;
    was_rst = rst;
    g_exu = 1'b0; g_lsu = 1'b0;
    if (!rst) begin
      if (bus.exu_valid && bus.lsu_valid) begin
        if (m_last_lsu) g_exu = 1'b1; else g_lsu = 1'b1;
      end else begin
        g_exu = bus.exu_valid;
        g_lsu = bus.lsu_valid;
      end
    end
    check_eq("exu_ready", bus.exu_ready, g_exu);
    check_eq("lsu_ready", bus.lsu_ready, g_lsu);
    if (!rst) begin
      check_eq("rs1_busy", rs1_busy, m_busy(chk_rs1));
      check_eq("rs2_busy", rs2_busy, m_busy(chk_rs2));
    end
    grd   = g_lsu ? int'(bus.lsu_rd) : int'(bus.exu_rd);
    gdata = g_lsu ? bus.lsu_data : bus.exu_data;
    ird   = int'(issue_rd);
    inc_ok = issue_v && real_rd(ird);
    dec_ok = (g_exu || g_lsu) && real_rd(grd);
    @(posedge clk);
    #1;
    if (was_rst) begin
      model_reset();
    end else begin
      m_wen = dec_ok;
      if (g_exu || g_lsu) begin m_waddr = grd; m_wdata = gdata; end
      if (g_exu) m_last_lsu = 1'b0;
      else if (g_lsu) m_last_lsu = 1'b1;
      if (!(inc_ok && dec_ok && ird == grd)) begin
        if (inc_ok) begin
          if (m_cnt[ird] == 3) m_err = 1'b1; else m_cnt[ird]++;
        end
        if (dec_ok) begin
          if (m_cnt[grd] == 0) m_err = 1'b1; else m_cnt[grd]--;
        end
      end
    end
    check_eq("rf_wen", bus.rf_wen, m_wen);
    if (m_wen || was_rst) begin
      check_eq("rf_waddr", bus.rf_waddr, m_waddr);
      check_eq("rf_wdata", bus.rf_wdata, m_wdata);
    end
    check_eq("sb_err", sb_err, m_err);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    idle();
    bus.exu_rd = '0; bus.exu_data = '0; bus.lsu_rd = '0; bus.lsu_data = '0;
    issue_rd = '0; chk_rs1 = '0; chk_rs2 = '0;

    // Reset state; ready must stay low while rst even with a request pending
    bus.exu_valid = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_wen", bus.rf_wen, 0);
    check_eq("rst_waddr", bus.rf_waddr, 0);
    check_eq("rst_wdata", bus.rf_wdata, 0);
    check_eq("rst_sberr", sb_err, 0);

    // Single EXU write
    do_reset();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd5; bus.exu_data = 32'h1234;
    #1 check_eq("single_ready", bus.exu_ready, 1);
    step();
    idle();
    check_eq("single_wen", bus.rf_wen, 1);
    check_eq("single_waddr", bus.rf_waddr, 5);
    check_eq("single_wdata", bus.rf_wdata, 32'h1234);
    step();

    // Both valid -> alternate EXU, LSU, EXU, LSU
    do_reset();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd3; bus.exu_data = 32'hAAAA_0003;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'hBBBB_0004;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("alt_waddr", bus.rf_waddr, (i % 2 == 0) ? 3 : 4);
    end
    idle();

    // RAW: busy through the rf_wen cycle, clear after
    do_reset();
    issue_v = 1'b1; issue_rd = 5'd7;
    step();
    issue_v = 1'b0; chk_rs1 = 5'd7;
    #1 check_eq("raw_busy_issued", rs1_busy, 1);
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'hCAFE_0007;
    step();
    bus.lsu_valid = 1'b0;
    check_eq("raw_busy_wen", rs1_busy, 1);
    step();
    check_eq("raw_busy_done", rs1_busy, 0);

    // Same-cycle issue and retire of one register
    do_reset();
    chk_rs2 = 5'd2;
    issue_v = 1'b1; issue_rd = 5'd2;
    step();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd2; bus.exu_data = 32'h2222;
    step();
    idle();
    step();
    check_eq("same_busy", rs2_busy, 1);
    check_eq("same_sberr", sb_err, 0);

    // x0 / out-of-range destinations, then counter overflow
    do_reset();
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd0; bus.exu_data = 32'h0;
    step();
    check_eq("x0_wen", bus.rf_wen, 0);
    bus.exu_rd = 5'd20;
    step();
    check_eq("oor_wen", bus.rf_wen, 0);
    idle();
    issue_v = 1'b1; issue_rd = 5'd9;
    for (int i = 0; i < 4; i++) step();
    check_eq("ovf_sberr", sb_err, 1);
    issue_v = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_eq("ovf_hold", sb_err, 1);

    // Reset the cycle after an accept
    do_reset();
    chk_rs1 = 5'd5;
    issue_v = 1'b1; issue_rd = 5'd5;
    step();
    issue_v = 1'b0;
    bus.exu_valid = 1'b1; bus.exu_rd = 5'd5; bus.exu_data = 32'h5555;
    step();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd6;
    rst = 1'b1;
    #1;
    check_eq("rstmid_exu_ready", bus.exu_ready, 0);
    check_eq("rstmid_lsu_ready", bus.lsu_ready, 0);
    step();
    rst = 1'b0;
    idle();
    check_eq("rstmid_wen", bus.rf_wen, 0);
    check_eq("rstmid_busy", rs1_busy, 0);
    check_eq("rstmid_sberr", sb_err, 0);

    // Randomized traffic; sources hold requests until accepted
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (!bus.exu_valid || g_exu) begin
        bus.exu_valid = 1'($urandom_range(0, 1));
        bus.exu_rd    = 5'($urandom_range(0, 17));
        bus.exu_data  = $urandom;
      end
      if (!bus.lsu_valid || g_lsu) begin
        bus.lsu_valid = 1'($urandom_range(0, 1));
        bus.lsu_rd    = 5'($urandom_range(0, 17));
        bus.lsu_data  = $urandom;
      end
      issue_v  = ($urandom_range(0, 2) == 0);
      issue_rd = 5'($urandom_range(0, 17));
      chk_rs1  = 5'($urandom_range(0, 17));
      chk_rs2  = 5'($urandom_range(0, 17));
      rst      = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
